// File: rtl/keypad_matrix_scan.sv
// Row-scanning keypad controller: drives one row at a time, debounces the sensed
// columns and reports single-key press events with optional auto-repeat.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | rows off, scan restarts at row 0
// DRIVE    | drive the current row, clear the counter
// SETTLE   | wait for the column lines to settle, look for a press
// DEBOUNCE | require a stable column pattern for DEBOUNCE cycles
// PRESSED  | one-cycle key event, latch key_row/key_col
// HOLD     | key held on the current row, auto-repeat timing
// RELEASE  | require DEBOUNCE released cycles before scanning resumes
module keypad_matrix_scan #(
  parameter int NROWS        = 4,
  parameter int NCOLS        = 4,
  parameter int SCAN_DELAY   = 2,
  parameter int DEBOUNCE     = 15,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_DELAY = 300,
  parameter int REPEAT_RATE  = 100
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCOLS-1:0]         col,
  output logic [NROWS-1:0]         rows,
  output logic                     key_valid,
  output logic [$clog2(NROWS)-1:0] key_row,
  output logic [$clog2(NCOLS)-1:0] key_col,
  output logic                     key_repeat,
  output logic                     multi_err
);

  localparam int RW      = $clog2(NROWS);
  localparam int CW      = $clog2(NCOLS);
  localparam int MAX_A   = (SCAN_DELAY > DEBOUNCE) ? SCAN_DELAY : DEBOUNCE;
  localparam int MAX_B   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  localparam logic [CNTW-1:0] CNT_SAT = CNTW'(CNT_MAX);
  localparam logic [CNTW-1:0] SD_LIM  = CNTW'(SCAN_DELAY);
  localparam logic [CNTW-1:0] DB_LIM  = CNTW'(DEBOUNCE);
  localparam logic [CNTW-1:0] REL_LIM = CNTW'(DEBOUNCE - 1);
  // In HOLD the counter reads 0 on the cycle after each key_valid pulse and the
  // repeat pulse is registered, so period P fires when the counter reaches P-2.
  // REPEAT_DELAY and REPEAT_RATE must therefore be at least 2.
  localparam logic [CNTW-1:0] RD_LIM  = CNTW'(REPEAT_DELAY - 2);
  localparam logic [CNTW-1:0] RR_LIM  = CNTW'(REPEAT_RATE - 2);
  localparam logic [RW-1:0]   LAST_ROW = RW'(NROWS - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DRIVE    = 3'd1;
  localparam logic [2:0] S_SETTLE   = 3'd2;
  localparam logic [2:0] S_DEBOUNCE = 3'd3;
  localparam logic [2:0] S_PRESSED  = 3'd4;
  localparam logic [2:0] S_HOLD     = 3'd5;
  localparam logic [2:0] S_RELEASE  = 3'd6;

  logic [2:0]       state;
  logic [RW-1:0]    scan_idx;
  logic [RW-1:0]    next_idx;
  logic [CNTW-1:0]  cnt;
  logic [CNTW-1:0]  cnt_inc;
  logic [NCOLS-1:0] col_m;
  logic [NCOLS-1:0] col_s;
  logic [NCOLS-1:0] cap_col;
  logic             cap_onehot;
  logic             key_ok;
  logic             rep_next;

  function automatic logic [CW-1:0] col_index(input logic [NCOLS-1:0] v);
    col_index = '0;
    for (int i = 0; i < NCOLS; i++) begin
      if (v[i]) col_index = CW'(i);
    end
  endfunction

  assign cnt_inc    = (cnt == CNT_SAT) ? cnt : cnt + CNTW'(1);
  assign next_idx   = (scan_idx == LAST_ROW) ? '0 : scan_idx + RW'(1);
  assign cap_onehot = ((cap_col & (cap_col - NCOLS'(1))) == '0);
  assign rows       = (state == S_IDLE) ? '0 : (NROWS'(1) << scan_idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      scan_idx   <= '0;
      cnt        <= '0;
      col_m      <= '0;
      col_s      <= '0;
      cap_col    <= '0;
      key_ok     <= 1'b0;
      rep_next   <= 1'b0;
      key_valid  <= 1'b0;
      key_repeat <= 1'b0;
      multi_err  <= 1'b0;
      key_row    <= '0;
      key_col    <= '0;
    end else begin
      col_m      <= col;
      col_s      <= col_m;
      key_valid  <= 1'b0;
      key_repeat <= 1'b0;
      multi_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt      <= '0;
          scan_idx <= '0;
          state    <= S_DRIVE;
        end
        S_DRIVE: begin
          cnt   <= '0;
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (col_s != '0) begin
            cap_col <= col_s;
            cnt     <= '0;
            state   <= S_DEBOUNCE;
          end else if (cnt >= SD_LIM) begin
            scan_idx <= next_idx;
            state    <= S_DRIVE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_DEBOUNCE: begin
          if (col_s == '0) begin
            scan_idx <= next_idx;
            state    <= S_DRIVE;
          end else if (col_s != cap_col) begin
            cap_col <= col_s;
            cnt     <= '0;
          end else if (cnt >= DB_LIM) begin
            if (cap_onehot) begin
              key_row   <= scan_idx;
              key_col   <= col_index(cap_col);
              key_valid <= 1'b1;
              key_ok    <= 1'b1;
              rep_next  <= 1'b0;
              state     <= S_PRESSED;
            end else begin
              multi_err <= 1'b1;
              key_ok    <= 1'b0;
              cnt       <= '0;
              state     <= S_HOLD;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_PRESSED: begin
          cnt   <= '0;
          state <= S_HOLD;
        end
        S_HOLD: begin
          if ((col_s & cap_col) == '0) begin
            cnt   <= '0;
            state <= S_RELEASE;
          end else if (key_valid) begin
            cnt <= '0;
          end else begin
            cnt <= cnt_inc;
            if ((REPEAT_EN != 0) && key_ok && (cnt == (rep_next ? RR_LIM : RD_LIM))) begin
              key_valid  <= 1'b1;
              key_repeat <= 1'b1;
              rep_next   <= 1'b1;
            end
          end
        end
        S_RELEASE: begin
          if ((col_s & cap_col) != '0) begin
            cnt   <= '0;
            state <= S_HOLD;
          end else if (cnt >= REL_LIM) begin
            scan_idx <= next_idx;
            state    <= S_DRIVE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Directed bench for keypad_matrix_scan: default, auto-repeat and 6x3 instances
// share clock and reset; each has a single-key matrix model on its col input.
module tb_keypad_matrix_scan;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // default instance
  logic [3:0] rows_def, col_def, def_pcol = '0;
  logic [1:0] def_prow = '0;
  logic       kv_def, krep_def, me_def;
  logic [1:0] kr_def, kc_def;
  assign col_def = rows_def[def_prow] ? def_pcol : '0;

  keypad_matrix_scan u_def (
    .clk(clk), .reset(reset), .col(col_def), .rows(rows_def), .key_valid(kv_def),
    .key_row(kr_def), .key_col(kc_def), .key_repeat(krep_def), .multi_err(me_def)
  );

  // auto-repeat instance
  logic [3:0] rows_rep, col_rep, rep_pcol = '0;
  logic [1:0] rep_prow = '0;
  logic       kv_rep, krep_rep, me_rep;
  logic [1:0] kr_rep, kc_rep;
  assign col_rep = rows_rep[rep_prow] ? rep_pcol : '0;

  keypad_matrix_scan #(.REPEAT_EN(1)) u_rep (
    .clk(clk), .reset(reset), .col(col_rep), .rows(rows_rep), .key_valid(kv_rep),
    .key_row(kr_rep), .key_col(kc_rep), .key_repeat(krep_rep), .multi_err(me_rep)
  );

  // 6x3 instance
  logic [5:0] rows_63;
  logic [2:0] col_63, p63_col = '0, p63_row = '0;
  logic       kv_63, krep_63, me_63;
  logic [2:0] kr_63;
  logic [1:0] kc_63;
  assign col_63 = rows_63[p63_row] ? p63_col : '0;

  keypad_matrix_scan #(.NROWS(6), .NCOLS(3)) u_63 (
    .clk(clk), .reset(reset), .col(col_63), .rows(rows_63), .key_valid(kv_63),
    .key_row(kr_63), .key_col(kc_63), .key_repeat(krep_63), .multi_err(me_63)
  );

  // event recorders, sampled on the falling edge
  int cyc = 0;
  int def_kv_n = 0, def_me_n = 0, def_viol = 0;
  logic [1:0] def_row = '0, def_col = '0;
  logic def_rep = 1'b0, def_kv_q = 1'b0;
  int rep_t[$];
  logic rep_r[$];
  int rep_me_n = 0, rep_viol = 0;
  logic [1:0] rep_row = '0, rep_col = '0;
  logic rep_kv_q = 1'b0;
  int v63_kv_n = 0, v63_viol = 0, wraps63 = 0;
  logic [2:0] v63_row = '0;
  logic [1:0] v63_col = '0;
  logic [5:0] rows63_q = '0;
  logic v63_kv_q = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (kv_def) begin def_kv_n++; def_row = kr_def; def_col = kc_def; def_rep = krep_def; end
    if (me_def) def_me_n++;
    if ((kv_def && (def_kv_q || me_def)) || !$onehot0(rows_def)) def_viol++;
    def_kv_q = kv_def;
    if (kv_rep) begin rep_t.push_back(cyc); rep_r.push_back(krep_rep); rep_row = kr_rep; rep_col = kc_rep; end
    if (me_rep) rep_me_n++;
    if ((kv_rep && (rep_kv_q || me_rep)) || !$onehot0(rows_rep)) rep_viol++;
    rep_kv_q = kv_rep;
    if (kv_63) begin v63_kv_n++; v63_row = kr_63; v63_col = kc_63; end
    if ((kv_63 && (v63_kv_q || me_63)) || krep_63 || me_63 || !$onehot0(rows_63)) v63_viol++;
    v63_kv_q = kv_63;
    if (rows63_q == 6'b100000 && rows_63 == 6'b000001) wraps63++;
    rows63_q = rows_63;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k0, m0, n0, w0, lat;
    int seen_n;
    logic [3:0] seen [4];
    logic [3:0] prev;

    // reset state
    cycles(4);
    chk("rst_rows", rows_def, 0);
    chk("rst_kv", kv_def, 0);
    chk("rst_row", kr_def, 0);
    chk("rst_col", kc_def, 0);
    chk("rst_rep", krep_def, 0);
    chk("rst_me", me_def, 0);
    chk("rst_rows63", rows_63, 0);
    reset = 1'b1;
    cycles(40);

    // single press row 2 col 1 held 100 cycles, with latency bound
    k0 = def_kv_n; m0 = def_me_n;
    def_prow = 2'd2; def_pcol = 4'b0010;
    lat = 0;
    while (!kv_def && lat < 60) begin cycles(1); lat++; end
    chk("a_latency_le_35", (lat <= 35), 1);
    cycles(100 - lat);
    def_pcol = '0;
    cycles(60);
    chk("a_kv_count", def_kv_n - k0, 1);
    chk("a_key_row", def_row, 2);
    chk("a_key_col", def_col, 1);
    chk("a_key_repeat", def_rep, 0);
    chk("a_multi_err", def_me_n - m0, 0);

    // bouncing press row 0 col 3
    k0 = def_kv_n;
    def_prow = 2'd0;
    for (int i = 0; i < 6; i++) begin
      def_pcol = (i % 2 == 0) ? 4'b1000 : 4'b0000;
      cycles(5);
    end
    def_pcol = 4'b1000;
    cycles(100);
    def_pcol = '0;
    cycles(60);
    chk("b_kv_count", def_kv_n - k0, 1);
    chk("b_key_row", def_row, 0);
    chk("b_key_col", def_col, 3);

    // two columns in row 3, then a single key in row 3
    k0 = def_kv_n; m0 = def_me_n;
    def_prow = 2'd3; def_pcol = 4'b0101;
    cycles(80);
    def_pcol = '0;
    cycles(60);
    chk("c_multi_err", def_me_n - m0, 1);
    chk("c_no_kv", def_kv_n - k0, 0);
    def_pcol = 4'b0001;
    cycles(80);
    def_pcol = '0;
    cycles(60);
    chk("c_kv_after", def_kv_n - k0, 1);
    chk("c_key_row", def_row, 3);
    chk("c_key_col", def_col, 0);
    chk("c_me_after", def_me_n - m0, 1);

    // auto-repeat: row 1 col 0 held 600 cycles
    n0 = rep_t.size();
    rep_prow = 2'd1; rep_pcol = 4'b0001;
    cycles(600);
    rep_pcol = '0;
    cycles(60);
    chk("d_event_count", rep_t.size() - n0, 4);
    chk("d_first_gap", rep_t[n0+1] - rep_t[n0], 300);
    chk("d_second_gap", rep_t[n0+2] - rep_t[n0+1], 100);
    chk("d_third_gap", rep_t[n0+3] - rep_t[n0+2], 100);
    chk("d_rep_flag0", rep_r[n0], 0);
    chk("d_rep_flag1", rep_r[n0+1], 1);
    chk("d_rep_flag2", rep_r[n0+2], 1);
    chk("d_rep_flag3", rep_r[n0+3], 1);
    chk("d_key_row", rep_row, 1);
    chk("d_key_col", rep_col, 0);

    // multi-column hold on the repeat instance never repeats
    n0 = rep_t.size(); m0 = rep_me_n;
    rep_prow = 2'd2; rep_pcol = 4'b0011;
    cycles(600);
    rep_pcol = '0;
    cycles(60);
    chk("d_multi_no_kv", rep_t.size() - n0, 0);
    chk("d_multi_err", rep_me_n - m0, 1);

    // 6x3 press row 5 col 2, then idle wrap 5 -> 0
    k0 = v63_kv_n;
    p63_row = 3'd5; p63_col = 3'b100;
    cycles(100);
    p63_col = '0;
    cycles(60);
    chk("e_kv_count", v63_kv_n - k0, 1);
    chk("e_key_row", v63_row, 5);
    chk("e_key_col", v63_col, 2);
    w0 = wraps63;
    cycles(100);
    chk("e_wrap_seen", (wraps63 > w0), 1);

    // reset during HOLD
    def_prow = 2'd1; def_pcol = 4'b0100;
    lat = 0;
    while (!kv_def && lat < 60) begin cycles(1); lat++; end
    chk("f_press_seen", kv_def, 1);
    cycles(5);
    reset = 1'b0;
    #1;
    chk("f_rst_rows", rows_def, 0);
    chk("f_rst_kv", kv_def, 0);
    chk("f_rst_row", kr_def, 0);
    chk("f_rst_col", kc_def, 0);
    chk("f_rst_rep", krep_def, 0);
    chk("f_rst_me", me_def, 0);
    def_pcol = '0;
    cycles(3);
    reset = 1'b1;
    k0 = def_kv_n;
    seen_n = 0; prev = '0;
    seen[0] = '0; seen[1] = '0; seen[2] = '0; seen[3] = '0;
    for (int i = 0; i < 30; i++) begin
      cycles(1);
      if (rows_def != '0 && rows_def != prev && seen_n < 4) begin
        seen[seen_n] = rows_def;
        seen_n++;
      end
      prev = rows_def;
    end
    chk("f_walk0", seen[0], 1);
    chk("f_walk1", seen[1], 2);
    chk("f_walk2", seen[2], 4);
    chk("f_walk3", seen[3], 8);
    cycles(40);
    chk("f_no_spurious_kv", def_kv_n - k0, 0);

    // pulse invariants and one-hot rows across the whole run
    chk("g_def_invariants", def_viol, 0);
    chk("g_rep_invariants", rep_viol, 0);
    chk("g_63_invariants", v63_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
